// File: rtl/matmul_share_sched.sv
// Two-requester round-robin scheduler around a shared 2x2 int8 matmul engine.
// One result element is computed per CALC cycle, then held until it is consumed.
module matmul_share_sched #(
  parameter int OPW  = 8,
  parameter int OUTW = 32,
  parameter int CNTW = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [4*OPW-1:0] req0_a,
  input  logic [4*OPW-1:0] req0_b,
  input  logic             req0_relu,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [4*OPW-1:0] req1_a,
  input  logic [4*OPW-1:0] req1_b,
  input  logic             req1_relu,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [OUTW-1:0]  out_p00,
  output logic [OUTW-1:0]  out_p01,
  output logic [OUTW-1:0]  out_p10,
  output logic [OUTW-1:0]  out_p11,
  output logic             busy,
  output logic [CNTW-1:0]  cycle_count,
  output logic [CNTW-1:0]  job_count
);
  localparam int SW = 2*OPW+1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e            state_q, state_d;
  logic              last_q, grant, acc;
  logic [1:0]        elem_q;
  logic [4*OPW-1:0]  a_q, b_q;
  logic              relu_q, id_q;
  logic              out_valid_q, out_id_q;
  logic [OUTW-1:0]   p00_q, p01_q, p10_q, p11_q;
  logic [CNTW-1:0]   cycle_q, job_q;

  logic signed [OPW-1:0]   x1, x2, y1, y2;
  logic signed [2*OPW-1:0] m1, m2;
  logic [SW-1:0]           sum;
  logic [OUTW-1:0]         elem_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (acc) state_d = CALC;
      CALC:    if (elem_q == 2'd3) state_d = DONE;
      DONE:    if (out_valid_q && out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // When both ask, the requester not served last time wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_q;
    else                          grant = req1_valid;
    req0_ready = (state_q == IDLE) && !grant;
    req1_ready = (state_q == IDLE) && grant;
    busy       = (state_q != IDLE);
  end

  assign acc = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  // elem_q[1] picks the A row, elem_q[0] picks the B column.
  always_comb begin
    x1 = elem_q[1] ? a_q[2*OPW-1 -: OPW] : a_q[4*OPW-1 -: OPW];
    x2 = elem_q[1] ? a_q[OPW-1:0]        : a_q[3*OPW-1 -: OPW];
    y1 = elem_q[0] ? b_q[3*OPW-1 -: OPW] : b_q[4*OPW-1 -: OPW];
    y2 = elem_q[0] ? b_q[OPW-1:0]        : b_q[2*OPW-1 -: OPW];
    m1 = x1 * y1;
    m2 = x2 * y2;
    sum = {m1[2*OPW-1], m1} + {m2[2*OPW-1], m2};
    if (relu_q && sum[SW-1]) elem_v = '0;
    else                     elem_v = {{(OUTW-SW){sum[SW-1]}}, sum};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q      <= 1'b1;
      elem_q      <= 2'd0;
      a_q         <= '0;
      b_q         <= '0;
      relu_q      <= 1'b0;
      id_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      p00_q       <= '0;
      p01_q       <= '0;
      p10_q       <= '0;
      p11_q       <= '0;
      cycle_q     <= '0;
      job_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: if (acc) begin
          a_q    <= grant ? req1_a : req0_a;
          b_q    <= grant ? req1_b : req0_b;
          relu_q <= grant ? req1_relu : req0_relu;
          id_q   <= grant;
          last_q <= grant;
          elem_q <= 2'd0;
        end
        CALC: begin
          cycle_q <= cycle_q + CNTW'(1);
          elem_q  <= elem_q + 2'd1;
          unique case (elem_q)
            2'd0: p00_q <= elem_v;
            2'd1: p01_q <= elem_v;
            2'd2: p10_q <= elem_v;
            2'd3: p11_q <= elem_v;
          endcase
          if (elem_q == 2'd3) begin
            out_valid_q <= 1'b1;
            out_id_q    <= id_q;
          end
        end
        DONE: if (out_valid_q && out_ready) begin
          out_valid_q <= 1'b0;
          job_q       <= job_q + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_id      = out_id_q;
  assign out_p00     = p00_q;
  assign out_p01     = p01_q;
  assign out_p10     = p10_q;
  assign out_p11     = p11_q;
  assign cycle_count = cycle_q;
  assign job_count   = job_q;

endmodule

// File: tb/tb_matmul_share_sched.sv
// Directed bench for matmul_share_sched.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_matmul_share_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req0_ready;
  logic [31:0] req0_a = '0, req0_b = '0;
  logic        req0_relu = 1'b0;
  logic        req1_valid = 1'b0, req1_ready;
  logic [31:0] req1_a = '0, req1_b = '0;
  logic        req1_relu = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_id;
  logic [31:0] out_p00, out_p01, out_p10, out_p11;
  logic        busy;
  logic [31:0] cycle_count, job_count;

  int checks = 0;
  int errors = 0;
  int cc_exp = 0;
  int jc_exp = 0;

  matmul_share_sched #(.OPW(8), .OUTW(32), .CNTW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_relu(req0_relu),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_relu(req1_relu),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
    .out_p00(out_p00), .out_p01(out_p01),
    .out_p10(out_p10), .out_p11(out_p11),
    .busy(busy), .cycle_count(cycle_count), .job_count(job_count)
  );

  always #5 clk = ~clk;

  // Drive one request, hold it until accepted, drop it after the accept edge.
  task automatic drive_req(input int n, input logic [31:0] a,
                           input logic [31:0] b, input logic relu,
                           output int waited);
    @(negedge clk);
    if (n == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_relu = relu;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_relu = relu;
    end
    #1;
    waited = 0;
    while (!((n == 0) ? req0_ready : req1_ready) && waited < 20) begin
      @(negedge clk); #1;
      waited++;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_job(input int n, input logic [31:0] a,
                         input logic [31:0] b, input logic relu,
                         output int lat);
    int w;
    drive_req(n, a, b, relu, w);
    if (w >= 20) lat = 99;
    else wait_valid(lat);
    cc_exp += 4;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_id, busy, out_p00, out_p01, out_p10, out_p11,
         cycle_count, job_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b id=%b busy=%b p=%h %h %h %h cc=%0d jc=%0d want all zero",
               out_valid, out_id, busy, out_p00, out_p01, out_p10, out_p11,
               cycle_count, job_count);
    end
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_grant got %b want 10", {req0_ready, req1_ready});
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_basic();
    int lat;
    out_ready = 1'b1;
    run_job(0, 32'h01020304, 32'h05060708, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL basic_latency got %0d want 4", lat);
    end
    checks++;
    if ({out_p00, out_p01, out_p10, out_p11} !==
        {32'd19, 32'd22, 32'd43, 32'd50}) begin
      errors++;
      $display("FAIL basic_result got %0d %0d %0d %0d want 19 22 43 50",
               out_p00, out_p01, out_p10, out_p11);
    end
    checks++;
    if ({out_id, busy, cycle_count} !== {1'b0, 1'b1, 32'd4}) begin
      errors++;
      $display("FAIL basic_status got id=%b busy=%b cc=%0d want id=0 busy=1 cc=4",
               out_id, busy, cycle_count);
    end
    @(negedge clk);
    jc_exp++;
    checks++;
    if ({out_valid, busy, job_count} !== {1'b0, 1'b0, 32'd1}) begin
      errors++;
      $display("FAIL basic_handshake got v=%b busy=%b jc=%0d want v=0 busy=0 jc=1",
               out_valid, busy, job_count);
    end
  endtask

  task automatic test_relu();
    int lat;
    run_job(1, 32'hFF0000FF, 32'h02000003, 1'b0, lat);
    checks++;
    if ({lat[7:0], out_id, out_p00, out_p01, out_p10, out_p11} !==
        {8'd4, 1'b1, 32'hFFFFFFFE, 32'd0, 32'd0, 32'hFFFFFFFD}) begin
      errors++;
      $display("FAIL relu_off got lat=%0d id=%b p=%h %h %h %h want lat=4 id=1 p=fffffffe 0 0 fffffffd",
               lat, out_id, out_p00, out_p01, out_p10, out_p11);
    end
    @(negedge clk);
    jc_exp++;
    run_job(1, 32'hFF0000FF, 32'h02000003, 1'b1, lat);
    checks++;
    if ({lat[7:0], out_p00, out_p01, out_p10, out_p11} !== {8'd4, 128'd0}) begin
      errors++;
      $display("FAIL relu_on got lat=%0d p=%h %h %h %h want lat=4 all zero",
               lat, out_p00, out_p01, out_p10, out_p11);
    end
    @(negedge clk);
    jc_exp++;
  endtask

  task automatic test_extremes();
    int lat;
    run_job(0, 32'h80808080, 32'h80808080, 1'b0, lat);
    checks++;
    if ({out_p00, out_p01, out_p10, out_p11} !== {4{32'h00008000}}) begin
      errors++;
      $display("FAIL ext_min_min got %h %h %h %h want 00008000 each",
               out_p00, out_p01, out_p10, out_p11);
    end
    @(negedge clk);
    jc_exp++;
    run_job(0, 32'h7F7F7F7F, 32'h80808080, 1'b0, lat);
    checks++;
    if ({out_p00, out_p01, out_p10, out_p11} !== {4{32'hFFFF8100}}) begin
      errors++;
      $display("FAIL ext_max_min got %h %h %h %h want ffff8100 each",
               out_p00, out_p01, out_p10, out_p11);
    end
    @(negedge clk);
    jc_exp++;
    checks++;
    if ({cycle_count, job_count} !== {cc_exp[31:0], jc_exp[31:0]}) begin
      errors++;
      $display("FAIL ext_counters got cc=%0d jc=%0d want cc=%0d jc=%0d",
               cycle_count, job_count, cc_exp, jc_exp);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    run_job(0, 32'h01020304, 32'h05060708, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL bp_latency got %0d want 4", lat);
    end
    req1_valid = 1'b1;
    req1_a = 32'hFF0000FF;
    req1_b = 32'h02000003;
    req1_relu = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if ({out_valid, out_id, req0_ready, req1_ready, busy,
           out_p00, out_p01, out_p10, out_p11, cycle_count} !==
          {5'b10001, 32'd19, 32'd22, 32'd43, 32'd50, cc_exp[31:0]}) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b id=%b rdy=%b%b busy=%b p=%0d %0d %0d %0d cc=%0d want v=1 id=0 rdy=00 busy=1 p=19 22 43 50 cc=%0d",
                 i, out_valid, out_id, req0_ready, req1_ready, busy,
                 out_p00, out_p01, out_p10, out_p11, cycle_count, cc_exp);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    jc_exp++;
    #1;
    checks++;
    if ({out_valid, busy, req1_ready, job_count} !==
        {3'b001, jc_exp[31:0]}) begin
      errors++;
      $display("FAIL bp_release got v=%b busy=%b r1rdy=%b jc=%0d want v=0 busy=0 r1rdy=1 jc=%0d",
               out_valid, busy, req1_ready, job_count, jc_exp);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept got busy=%b want 1", busy);
    end
    wait_valid(lat);
    cc_exp += 4;
    checks++;
    if ({lat[7:0], out_id, out_p00, out_p11} !==
        {8'd4, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFD}) begin
      errors++;
      $display("FAIL bp_next_job got lat=%0d id=%b p00=%h p11=%h want lat=4 id=1 p00=fffffffe p11=fffffffd",
               lat, out_id, out_p00, out_p11);
    end
    @(negedge clk);
    jc_exp++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] ids;
    int got, n0, cyc;
    bit both_hi, bad_p;
    ids = '0; got = 0; n0 = 0; cyc = 0; both_hi = 0; bad_p = 0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    req0_a = 32'h01020304; req0_b = 32'h05060708; req0_relu = 1'b0;
    req1_a = 32'h01000001; req1_b = 32'h09000000; req1_relu = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rst_n = 1'b1;
    cc_exp = 0;
    jc_exp = 0;
    while (got < 4 && cyc < 60) begin
      #1;
      if (req0_ready && req1_ready) both_hi = 1;
      if (out_valid) begin
        ids[got] = out_id;
        if (out_id == 1'b0) n0++;
        if (out_p00 !== (out_id ? 32'd9 : 32'd19)) bad_p = 1;
        got++;
        if (got == 4) begin
          req0_valid = 1'b0;
          req1_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    cc_exp = 16;
    jc_exp = 4;
    checks++;
    if ({got[7:0], ids} !== {8'd4, 4'b1010}) begin
      errors++;
      $display("FAIL b2b_order got jobs=%0d ids(3..0)=%b want jobs=4 ids=1010",
               got, ids);
    end
    checks++;
    if ({both_hi, bad_p, n0[7:0]} !== {2'b00, 8'd2}) begin
      errors++;
      $display("FAIL b2b_fair got both_ready=%b bad_result=%b req0_jobs=%0d want 0 0 2",
               both_hi, bad_p, n0);
    end
    checks++;
    if ({busy, cycle_count, job_count} !== {1'b0, 32'd16, 32'd4}) begin
      errors++;
      $display("FAIL b2b_counters got busy=%b cc=%0d jc=%0d want busy=0 cc=16 jc=4",
               busy, cycle_count, job_count);
    end
  endtask

  task automatic test_midreset();
    int w, lat;
    out_ready = 1'b1;
    drive_req(0, 32'h01020304, 32'h05060708, 1'b0, w);
    @(negedge clk);
    checks++;
    if ({busy, out_p00} !== {1'b1, 32'd19}) begin
      errors++;
      $display("FAIL mid_precheck got busy=%b p00=%0d want busy=1 p00=19",
               busy, out_p00);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_id, busy, out_p00, out_p01, out_p10, out_p11,
         cycle_count, job_count} !== '0) begin
      errors++;
      $display("FAIL mid_reset got v=%b busy=%b p=%h %h %h %h cc=%0d jc=%0d want all zero",
               out_valid, busy, out_p00, out_p01, out_p10, out_p11,
               cycle_count, job_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    checks++;
    if ({out_valid, req0_ready, req1_ready} !== 3'b010) begin
      errors++;
      $display("FAIL mid_first_grant got v=%b rdy=%b%b want v=0 rdy=10",
               out_valid, req0_ready, req1_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_valid(lat);
    checks++;
    if ({lat[7:0], out_id, out_p00, out_p11, cycle_count} !==
        {8'd4, 1'b0, 32'd19, 32'd50, 32'd4}) begin
      errors++;
      $display("FAIL mid_after got lat=%0d id=%b p00=%0d p11=%0d cc=%0d want lat=4 id=0 p00=19 p11=50 cc=4",
               lat, out_id, out_p00, out_p11, cycle_count);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_relu();
    test_extremes();
    test_backpressure();
    test_back_to_back();
    test_midreset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
